// File: rtl/icache_sa.sv
// Blocking N-way set-associative instruction cache with per-set round-robin
// replacement and sequenced flush. Optional hit/miss counters: ICACHE_STATS_EN.
module icache_sa #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 16,
    parameter int unsigned WAYS       = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_data,
    input  logic              invalidate,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic              mem_resp_last
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int unsigned OFF_W    = $clog2(DATA_W / 8);
    localparam int unsigned WORD_W   = $clog2(LINE_WORDS);
    localparam int unsigned SET_W    = $clog2(SETS);
    localparam int unsigned LINE_LSB = OFF_W + WORD_W;
    localparam int unsigned TAG_LSB  = LINE_LSB + SET_W;
    localparam int unsigned TAG_W    = ADDR_W - TAG_LSB;
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESPOND, S_FLUSH
    } state_t;

    state_t r_state, w_next;

    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS][LINE_WORDS];
    logic [WAY_W-1:0]  r_rr    [SETS];

    logic [ADDR_W-1:0] r_addr;
    logic [WAY_W-1:0]  r_victim;
    logic [WORD_W-1:0] r_beat;
    logic [SET_W-1:0]  r_flush;
    logic              r_pending;
    logic [DATA_W-1:0] r_resp_data;

    logic [WORD_W-1:0] w_word;
    logic [SET_W-1:0]  w_set;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_victim;
    logic              w_found;
    logic              w_last_beat;
    logic              w_beat;
    logic              w_unused;

    assign w_word      = r_addr[OFF_W +: WORD_W];
    assign w_set       = r_addr[LINE_LSB +: SET_W];
    assign w_tag       = r_addr[TAG_LSB +: TAG_W];
    assign w_last_beat = (r_beat == WORD_W'(LINE_WORDS - 1));
    assign w_beat      = (r_state == S_REFILL) && mem_resp_valid;
    assign w_unused    = ^{mem_resp_last, r_addr};

    // Hit search and victim choice (lowest invalid way, else the RR way).
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_found   = 1'b0;
        w_victim  = r_rr[w_set];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag) && !w_hit) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_set][w] && !w_found) begin
                w_found  = 1'b1;
                w_victim = WAY_W'(w);
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_data  = '0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = '0;
        case (r_state)
            S_IDLE: begin
                cpu_req_ready = !invalidate;
                if (invalidate)         w_next = S_FLUSH;
                else if (cpu_req_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP:   w_next = w_hit ? S_RESPOND : S_MISS_REQ;
            S_MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {w_tag, w_set, {LINE_LSB{1'b0}}};
                if (mem_req_ready) w_next = S_REFILL;
            end
            S_REFILL:   if (w_beat && w_last_beat) w_next = S_RESPOND;
            S_RESPOND: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_data  = r_resp_data;
                w_next = (r_pending || invalidate) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH:    if (r_flush == SET_W'(SETS - 1)) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_victim    <= '0;
            r_beat      <= '0;
            r_flush     <= '0;
            r_pending   <= 1'b0;
            r_resp_data <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (!invalidate && cpu_req_valid) r_addr <= cpu_req_addr;
                S_LOOKUP: begin
                    r_victim <= w_victim;
                    if (w_hit) r_resp_data <= r_data[w_set][w_hit_way][w_word];
                end
                S_REFILL: if (mem_resp_valid) begin
                    r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                    if (r_beat == w_word) r_resp_data <= mem_resp_data;
                    if (w_last_beat) begin
                        r_valid[w_set][r_victim] <= 1'b1;
                        r_rr[w_set] <= (r_rr[w_set] == WAY_W'(WAYS - 1)) ? '0
                                                                           : r_rr[w_set] + 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_valid[r_flush] <= '0;
                    r_flush          <= r_flush + 1'b1;
                end
                default: ;
            endcase
            // Invalidate during an access is deferred until its response has gone out.
            if (invalidate && (r_state inside {S_LOOKUP, S_MISS_REQ, S_REFILL}))
                r_pending <= 1'b1;
            else if (r_state == S_RESPOND && w_next == S_FLUSH)
                r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (w_beat) begin
            r_data[w_set][r_victim][r_beat] <= mem_resp_data;
            if (w_last_beat) r_tag[w_set][r_victim] <= w_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit && hit_count != '1)        hit_count  <= hit_count + 1'b1;
            else if (!w_hit && miss_count != '1) miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa (default geometry): table of accesses plus
// hand sequences for flush, invalidate-during-refill and reset-mid-refill.
module tb_icache_sa;
    logic        clock = 1'b0;
    logic        reset, cpu_req_valid, cpu_req_ready, cpu_resp_valid, invalidate;
    logic [31:0] cpu_req_addr, cpu_resp_data, mem_req_addr, mem_resp_data;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_last;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clock = ~clock;

    icache_sa #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(16), .WAYS(2)) dut (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_data(cpu_resp_data), .invalidate(invalidate),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory image: word i of line L is (L - 0x1000) * 16 + 0xA0 + i.
    function automatic logic [31:0] fill(input logic [31:0] line, input int unsigned i);
        return (line - 32'h1000) * 32'd16 + 32'hA0 + 32'(i);
    endfunction

    // Issue one fetch from a negedge; return at the negedge showing the response.
    task automatic access(input logic [31:0] addr, input int stall, input bit inv_mid,
                          output bit was_miss, output logic [31:0] maddr,
                          output logic [31:0] data, output int hs, output int lat,
                          output int gap);
        int  n, beat, stall_left, last_n;
        bit  hs_done, got, seen;
        logic [31:0] first_addr;
        beat = 0; stall_left = stall; last_n = -100; hs_done = 0; got = 0; seen = 0;
        first_addr = '0; was_miss = 0; maddr = '0; data = '0; hs = 0; lat = -1; gap = -1;
        n = 0;
        while (!cpu_req_ready && n < 100) begin @(negedge clock); n++; end
        if (!cpu_req_ready) chk("req_ready_wait", 32'(cpu_req_ready), 32'd1);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            cpu_req_valid = 1'b0;
            if (cpu_resp_valid) begin
                data = cpu_resp_data; lat = c; gap = c - last_n; got = 1;
                break;
            end
            mem_resp_valid = 1'b0; mem_resp_last = 1'b0; invalidate = 1'b0;
            if (hs_done && beat < 4) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = fill(maddr, beat);
                mem_resp_last  = (beat == 3);
                if (inv_mid && beat == 2) invalidate = 1'b1;
                beat++; last_n = c;
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                was_miss = 1;
                if (!seen) begin first_addr = mem_req_addr; seen = 1; end
                else chk("req_addr_stable", mem_req_addr, first_addr);
                if (stall_left > 0) stall_left--;
                else begin mem_req_ready = 1'b1; hs++; maddr = mem_req_addr; hs_done = 1; end
            end
        end
        if (!got) chk("resp_timeout", 32'(cpu_resp_valid), 32'd1);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0; invalidate = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [31:0] maddr;
        logic [31:0] data;
        int          stall;
    } vec_t;

    vec_t tbl[11];

    task automatic run_vec(input vec_t v, input bit inv_mid);
        bit was_miss; logic [31:0] maddr, data; int hs, lat, gap;
        access(v.addr, v.stall, inv_mid, was_miss, maddr, data, hs, lat, gap);
        chk("miss_flag", 32'(was_miss), 32'(v.miss));
        chk("resp_data", data, v.data);
        if (v.miss) begin
            chk("refill_addr", maddr, v.maddr);
            chk("handshakes", 32'(hs), 32'd1);
            chk("miss_latency", 32'(gap), 32'd1);
        end else begin
            chk("hit_latency", 32'(lat), 32'd2);
        end
    endtask

    task automatic flush_window(input string name);
        int busy;
        busy = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (!cpu_req_ready && !cpu_resp_valid && !mem_req_valid) busy++;
        end
        chk(name, 32'(busy), 32'd16);
        @(negedge clock);
        chk("ready_after_flush", 32'(cpu_req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int n;
        tbl[0]  = '{32'h0000_1004, 1, 32'h0000_1000, 32'h0000_00A1, 0};
        tbl[1]  = '{32'h0000_100C, 0, 32'h0,         32'h0000_00A3, 0};
        tbl[2]  = '{32'h0000_2008, 1, 32'h0000_2000, 32'h0001_00A2, 0};
        tbl[3]  = '{32'h0000_3000, 1, 32'h0000_3000, 32'h0002_00A0, 0};
        tbl[4]  = '{32'h0000_2000, 0, 32'h0,         32'h0001_00A0, 0};
        tbl[5]  = '{32'h0000_1000, 1, 32'h0000_1000, 32'h0000_00A0, 0};
        tbl[6]  = '{32'h0000_3004, 0, 32'h0,         32'h0002_00A1, 0};
        tbl[7]  = '{32'h0000_2004, 1, 32'h0000_2000, 32'h0001_00A1, 5};
        tbl[8]  = '{32'h0000_104C, 1, 32'h0000_1040, 32'h0000_04A3, 0};
        tbl[9]  = '{32'h0000_1048, 0, 32'h0,         32'h0000_04A2, 0};
        tbl[10] = '{32'h0000_100C, 0, 32'h0,         32'h0000_00A3, 0};

        reset = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = '0; invalidate = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_last = 1'b0;
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        chk("rst_ready", 32'(cpu_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_resp_data", cpu_resp_data, 32'd0);
        chk("rst_mem_req_addr", mem_req_addr, 32'd0);

        foreach (tbl[i]) run_vec(tbl[i], 1'b0);

        // Invalidate in IDLE wins over a simultaneous request.
        @(negedge clock);
        invalidate = 1'b1; cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_1000;
        @(negedge clock);
        invalidate = 1'b0; cpu_req_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (!cpu_req_ready && !cpu_resp_valid && !mem_req_valid) n++;
            if (i < 15) @(negedge clock);
        end
        chk("idle_flush_busy", 32'(n), 32'd16);
        @(negedge clock);
        chk("ready_after_idle_flush", 32'(cpu_req_ready), 32'd1);
        run_vec('{32'h0000_1000, 1, 32'h0000_1000, 32'h0000_00A0, 0}, 1'b0);

        // Invalidate pulsed mid-refill: response still correct, then a full flush.
        run_vec('{32'h0000_2048, 1, 32'h0000_2040, 32'h0001_04A2, 0}, 1'b1);
        flush_window("refill_flush_busy");
        run_vec('{32'h0000_2048, 1, 32'h0000_2040, 32'h0001_04A2, 0}, 1'b0);

        // Reset after two of four beats.
        @(negedge clock);
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_3008;
        @(negedge clock);
        cpu_req_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 20) begin @(negedge clock); n++; end
        chk("rst_seq_mem_req", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = fill(32'h3000, 0);
        @(negedge clock);
        mem_resp_data = fill(32'h3000, 1);
        @(negedge clock);
        mem_resp_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_ready", 32'(cpu_req_ready), 32'd1);
        chk("mid_rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        chk("mid_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("mid_rst_resp_data", cpu_resp_data, 32'd0);
        chk("mid_rst_mem_req_addr", mem_req_addr, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("mid_rst_hit_count", hit_count, 32'd0);
        chk("mid_rst_miss_count", miss_count, 32'd0);
`endif
        run_vec('{32'h0000_3008, 1, 32'h0000_3000, 32'h0002_00A2, 0}, 1'b0);
        run_vec('{32'h0000_300C, 0, 32'h0,         32'h0002_00A3, 0}, 1'b0);
`ifdef ICACHE_STATS_EN
        chk("stats_hit_count", hit_count, 32'd1);
        chk("stats_miss_count", miss_count, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised, blocking, N-way set-associative instruction cache.
- Next generation of the direct-mapped icache: configurable sets, ways, line length and data width; per-set round-robin replacement; sequenced invalidate.
- Sits between the fetch stage (CPU side) and the instruction memory/bus (line-refill burst side).

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, fetch word width in bits (power of two, >=8).
- LINE_WORDS, 4, words per line (power of two, >=2).
- SETS, 16, number of sets (power of two, >=2).
- WAYS, 2, associativity (power of two, >=1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  fetch request valid.
- cpu_req_ready  out  1  cache accepts request.
- cpu_req_addr  in  ADDR_W  fetch byte address; low log2(DATA_W/8) bits ignored.
- cpu_resp_valid  out  1  one-cycle response strobe; no backpressure.
- cpu_resp_data  out  DATA_W  fetched word.
- invalidate  in  1  pulse: invalidate entire cache.
- mem_req_valid  out  1  line refill request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  line-aligned refill address.
- mem_resp_valid  in  1  refill beat valid.
- mem_resp_data  in  DATA_W  refill beat, ascending word order.
- mem_resp_last  in  1  final beat marker.

Behaviour:
- Address split, LSB up: byte offset log2(DATA_W/8), word index log2(LINE_WORDS), set index log2(SETS), tag = remainder.
- Storage: valid, tag and data in flops/regs per set/way. Round-robin pointer per set, log2(WAYS) bits.
- FSM states:
  - IDLE: cpu_req_ready=1. valid&ready latches the address and moves to LOOKUP.
  - LOOKUP: compare all ways. Hit goes to RESPOND. Miss goes to MISS_REQ.
  - MISS_REQ: mem_req_valid=1, mem_req_addr = latched address with word/byte offset zeroed. Both held stable until mem_req_ready, then go to REFILL.
  - REFILL: beat counter from 0 writes beats into the victim way. On the beat with counter==LINE_WORDS-1: set valid and tag, advance the set's RR pointer, go to RESPOND.
  - RESPOND: cpu_resp_valid=1 with the requested word. Next state is FLUSH if an invalidate is pending, else IDLE.
  - FLUSH: clears valid for one set per cycle for SETS cycles, then goes to IDLE.
- Latency:
  - Hit: cpu_resp_valid is asserted 2 cycles after the accepting edge.
  - Miss: cpu_resp_valid is asserted in the cycle after the last refill beat.
- Victim selection: lowest-index invalid way. If all ways are valid, the set's RR pointer way.
- mem_resp_last is informational. Completion is decided by the beat counter. The counter wraps to 0 after the last beat.
- mem_resp_valid outside REFILL is ignored.
- invalidate:
  - In IDLE: go directly to FLUSH. An invalidate simultaneous with cpu_req_valid takes priority; the request is not accepted.
  - In LOOKUP, MISS_REQ or REFILL: set a pending flag. The current access completes and responds with its data, then FLUSH runs.
- cpu_req_ready=0 in every state except IDLE.
- Reset:
  - All valid bits, RR pointers, beat counter and pending flag clear. FSM goes to IDLE.
  - cpu_req_ready=1 in the first cycle after reset. cpu_resp_valid, mem_req_valid, cpu_resp_data and mem_req_addr are all 0.
  - Reset mid-refill discards the partial line; that line stays invalid.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count (32) and miss_count (32).
  - Each increments by 1 in LOOKUP on hit or miss respectively, saturating at 0xFFFF_FFFF.
  - Both clear on reset; invalidate does not clear them.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold miss, defaults:
  - Stimulus: request 0x0000_1004; mem_req_ready=1; beats 0xA0,0xA1,0xA2,0xA3 (last on the fourth).
  - Required: mem_req_addr=0x0000_1000 and exactly one request handshake; cpu_resp_data=0xA1 in the cycle after the fourth beat.
  - Follow-up: request 0x0000_100C hits, returns 0xA3 two cycles after acceptance, and mem_req_valid stays 0.
- Conflict/round-robin (WAYS=2):
  - Stimulus: fill 0x1000, 0x2000 and 0x3000 (all set 0).
  - Required: 0x3000 evicts the 0x1000 way. A new request to 0x2000 hits; a new request to 0x1000 misses with mem_req_addr=0x1000.
- Invalidate in IDLE:
  - Stimulus: after filling 0x1000, pulse invalidate.
  - Required: cpu_req_ready=0 for 16 cycles. Then a request to 0x1000 misses.
- Stall:
  - Stimulus: hold mem_req_ready=0 for 5 cycles on a miss.
  - Required: mem_req_valid=1 and mem_req_addr stay constant all 5 cycles; exactly one handshake occurs.
- Invalidate during REFILL:
  - Stimulus: pulse invalidate after the second beat.
  - Required: the refill completes and the response returns the correct word, followed by a 16-cycle FLUSH. A re-request to the same address misses.
- Reset mid-refill:
  - Stimulus: assert reset after 2 of 4 beats.
  - Required: next cycle all outputs are at reset values with cpu_req_ready=1. A request to the same address misses. With ICACHE_STATS_EN, hit_count=miss_count=0.
